simon_core_n: RTL and testbench
===============================

Name: simon_core_n

Overview:
- Parametrised Simon-game engine, the generalised successor of the fixed four-colour game core.
- Supports NUM_CH button/lamp channels, a configurable maximum sequence length, and configurable show/gap/timeout timing.
- Adds a player-response timeout and explicit win/lose indication.
- The sequence is regenerated from a stored LFSR seed on every replay, so no sequence RAM is needed.
- Sits between the synchronised button inputs and the lamp drivers inside the tt_um top level.

Parameters:
- NUM_CH, 4, number of colour channels (2..8).
- MAX_LEN, 16, rounds needed to win (1..255).
- SHOW_CYCLES, 4, cycles a lamp stays lit during playback (>=1).
- GAP_CYCLES, 2, dark cycles between playback symbols and before each playback (>=1).
- TIMEOUT_CYCLES, 50, idle cycles allowed in INPUT before a loss (>=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  clock enable; when low, all registers hold
- start  in  1  start/restart request (level; block edge-detects it)
- butt  in  NUM_CH  buttons, already synchronised, active high
- lamp  out  NUM_CH  lamp drive, active high
- level  out  8  current sequence length
- win  out  1  high in WIN state
- lose  out  1  high in LOSE state
- input_ready  out  1  high in INPUT state

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; lamp=0, level=0, win=0, lose=0, input_ready=0.
  - seed_cnt=0, len=0, idx=0, timers=0.
  - Edge-detect registers for start and butt are cleared to 0.
- Clock enable: all registers update only when ena=1, including the edge-detect history.
- Seed counter: 16-bit seed_cnt increments every enabled cycle, in all states.
- Start edge: a rising edge of start in IDLE, WIN or LOSE does the following, then enters PAUSE:
  - seed <= seed_cnt | 1 (value before this cycle's increment).
  - len <= 1.
- Start edges in any other state are ignored.
- LFSR:
  - 16-bit Galois, shift right; if lsb=1, XOR with 0xB400.
  - Reloaded from seed at the start of every playback and every INPUT phase.
  - Steps once per symbol consumed.
- Symbol: sym = (lfsr[7:0] * NUM_CH) >> 8, always in range 0..NUM_CH-1.
- States and transitions:
  - PAUSE: lamp=0 for GAP_CYCLES cycles; then lfsr <= seed, idx <= 0, go to SHOW_ON.
  - SHOW_ON: lamp = one-hot(sym) for SHOW_CYCLES cycles; then go to SHOW_OFF.
  - SHOW_OFF: lamp=0 for GAP_CYCLES cycles.
    - If idx == len-1: lfsr <= seed, idx <= 0, timer cleared, go to INPUT.
    - Otherwise: step lfsr, idx++, return to SHOW_ON.
  - INPUT: input_ready=1; lamp = butt (echo). A press is any rising edge on butt.
    - Exactly one bit rises, other bits low, and that bit equals sym: correct. Step lfsr, timer <= 0.
      - If idx < len-1: idx++.
      - Else if len == MAX_LEN: go to WIN.
      - Else: len++ and go to PAUSE.
    - Otherwise (wrong bit, two or more bits rising together, or a rise while another bit is held): go to LOSE.
    - No press: timer++. When the timer reaches TIMEOUT_CYCLES-1 with no press, go to LOSE.
  - WIN: win=1; all lamps toggle together every SHOW_CYCLES cycles, first phase on.
  - LOSE: lose=1; lamp = one-hot(expected sym) held steady; lfsr frozen.
- level = len in all states; it is retained in WIN/LOSE until the next start.
- Simultaneous events: a start edge in the same cycle as a button edge in INPUT is ignored (start only acts in IDLE/WIN/LOSE).
- Reset mid-game: immediate return to IDLE with all outputs at their reset values.

Test Plan:
- Reset, then ena=1 for 10 cycles -> lamp=0, level=0, win=lose=input_ready=0.
- NUM_CH=4, MAX_LEN=3. Raise start when seed_cnt=0x0005 -> seed=0x0005, level=1. After 2 dark cycles, lamp=4'b0001 for exactly 4 cycles, then 2 dark cycles, then input_ready=1.
- Continue the game with correct presses (stimulus derived from a reference LFSR model) -> level steps 1,2,3. After the third correct round: win=1, lamp toggles 4'hF/4'h0 every 4 cycles.
- In INPUT, press a wrong button -> next cycle lose=1, lamp = one-hot of expected symbol. Then a start edge restarts with level=1.
- In INPUT, raise butt=4'b0011 in one cycle -> LOSE. Separately, no press for 50 cycles -> LOSE on cycle 50. Also hold ena=0 for 20 cycles mid-INPUT -> timer frozen, no timeout.
- Assert rst_n=0 during SHOW_ON -> lamp=0 and level=0 immediately (asynchronous), state IDLE after release.

Source files
------------

// File: rtl/simon_core_n.sv
// Parametrised Simon-game engine: LFSR-regenerated sequence playback, player
// input checking with timeout, and win/lose indication.
module simon_core_n #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned SHOW_CYCLES    = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [NUM_CH-1:0] butt,
  output logic [NUM_CH-1:0] lamp,
  output logic [7:0]        level,
  output logic              win,
  output logic              lose,
  output logic              input_ready
);

  localparam int unsigned TMAX0 = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned TMAX  = (TIMEOUT_CYCLES > TMAX0) ? TIMEOUT_CYCLES : TMAX0;
  localparam int unsigned TW    = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PAUSE, S_SHOW_ON, S_SHOW_OFF, S_INPUT, S_WIN, S_LOSE
  } state_t;

  state_t            state;
  logic [15:0]       seed_cnt;
  logic [15:0]       seed;
  logic [15:0]       lfsr;
  logic [7:0]        len;
  logic [7:0]        idx;
  logic [TW-1:0]     timer;
  logic              start_q;
  logic [NUM_CH-1:0] butt_q;

  logic              start_rise;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] exp_oh;
  logic [15:0]       lfsr_next;
  logic              last;
  logic              can_start;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Scaling the low byte by NUM_CH maps it evenly onto 0..NUM_CH-1.
  function automatic logic [NUM_CH-1:0] sym_onehot(input logic [15:0] l);
    logic [15:0] p;
    p = {8'd0, l[7:0]} * 16'(NUM_CH);
    return NUM_CH'(1) << (p >> 8);
  endfunction

  always_comb begin
    start_rise = start & ~start_q;
    rise       = butt & ~butt_q;
    exp_oh     = sym_onehot(lfsr);
    lfsr_next  = lfsr_step(lfsr);
    last       = (idx == len - 8'd1);
    can_start  = (state == S_IDLE) || (state == S_WIN) || (state == S_LOSE);
  end

  assign level = len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      seed_cnt    <= '0;
      seed        <= '0;
      lfsr        <= '0;
      len         <= '0;
      idx         <= '0;
      timer       <= '0;
      start_q     <= 1'b0;
      butt_q      <= '0;
      lamp        <= '0;
      win         <= 1'b0;
      lose        <= 1'b0;
      input_ready <= 1'b0;
    end else if (ena) begin
      seed_cnt <= seed_cnt + 16'd1;
      start_q  <= start;
      butt_q   <= butt;
      if (start_rise && can_start) begin
        seed        <= seed_cnt | 16'd1;
        len         <= 8'd1;
        idx         <= '0;
        timer       <= '0;
        lamp        <= '0;
        win         <= 1'b0;
        lose        <= 1'b0;
        input_ready <= 1'b0;
        state       <= S_PAUSE;
      end else begin
        case (state)
          S_PAUSE: begin
            if (timer == TW'(GAP_CYCLES - 1)) begin
              timer <= '0;
              lfsr  <= seed;
              idx   <= '0;
              lamp  <= sym_onehot(seed);
              state <= S_SHOW_ON;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_SHOW_ON: begin
            if (timer == TW'(SHOW_CYCLES - 1)) begin
              timer <= '0;
              lamp  <= '0;
              state <= S_SHOW_OFF;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_SHOW_OFF: begin
            if (timer == TW'(GAP_CYCLES - 1)) begin
              timer <= '0;
              if (last) begin
                lfsr        <= seed;
                idx         <= '0;
                input_ready <= 1'b1;
                state       <= S_INPUT;
              end else begin
                lfsr  <= lfsr_next;
                idx   <= idx + 8'd1;
                lamp  <= sym_onehot(lfsr_next);
                state <= S_SHOW_ON;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_INPUT: begin
            lamp <= butt;
            // A correct press must be the only bit high, not merely the only bit rising.
            if (|rise && rise == exp_oh && butt == exp_oh) begin
              lfsr  <= lfsr_next;
              timer <= '0;
              if (!last) begin
                idx <= idx + 8'd1;
              end else if (len == 8'(MAX_LEN)) begin
                win         <= 1'b1;
                lamp        <= '1;
                input_ready <= 1'b0;
                state       <= S_WIN;
              end else begin
                len         <= len + 8'd1;
                lamp        <= '0;
                input_ready <= 1'b0;
                state       <= S_PAUSE;
              end
            end else if (|rise || timer == TW'(TIMEOUT_CYCLES - 1)) begin
              lose        <= 1'b1;
              lamp        <= exp_oh;
              input_ready <= 1'b0;
              state       <= S_LOSE;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_WIN: begin
            if (timer == TW'(SHOW_CYCLES - 1)) begin
              timer <= '0;
              lamp  <= ~lamp;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_simon_core_n.sv
// Directed bench for simon_core_n: reference LFSR model feeds a scoreboard of
// expected playback lamps and drives correct/incorrect presses.
module tb_simon_core_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic [3:0] butt;
  logic [3:0] lamp;
  logic [7:0] level;
  logic       win;
  logic       lose;
  logic       input_ready;

  int         checks = 0;
  int         failures = 0;
  int         cnt = 0;
  logic [15:0] seed_m;
  logic [3:0] sb[$];
  int         exp_syms[8];

  always #5 clk = ~clk;

  simon_core_n #(
    .NUM_CH(4),
    .MAX_LEN(3),
    .SHOW_CYCLES(4),
    .GAP_CYCLES(2),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .start(start),
    .butt(butt),
    .lamp(lamp),
    .level(level),
    .win(win),
    .lose(lose),
    .input_ready(input_ready)
  );

  function automatic logic [15:0] m_step(input logic [15:0] l);
    logic [15:0] r;
    r = {1'b0, l[15:1]};
    if (l[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic int m_sym(input logic [15:0] l);
    return (int'(l & 16'h00FF) * 4) / 256;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n && ena) cnt++;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_game();
    start  = 1'b1;
    seed_m = cnt[15:0] | 16'd1;
    tick();
    start = 1'b0;
    chk("start_level", 32'(level), 32'd1);
    chk("start_win", 32'(win), 32'd0);
    chk("start_lose", 32'(lose), 32'd0);
  endtask

  // Pushes the expected round into the scoreboard, then follows the playback.
  task automatic run_round(input int n);
    logic [15:0] l;
    logic [3:0]  e;
    int          dark;
    int          on;
    l = seed_m;
    for (int i = 0; i < n; i++) begin
      exp_syms[i] = m_sym(l);
      sb.push_back(4'(1 << exp_syms[i]));
      l = m_step(l);
    end
    for (int k = 0; k < n; k++) begin
      dark = 0;
      while (lamp == 4'd0 && dark < 40) begin dark++; tick(); end
      chk("gap", 32'(dark), 32'd2);
      e = 4'hx;
      if (sb.size() != 0) e = sb.pop_front();
      chk("show_sym", 32'(lamp), 32'(e));
      on = 0;
      while (lamp != 4'd0 && on < 40) begin on++; tick(); end
      chk("show_len", 32'(on), 32'd4);
    end
    dark = 0;
    while (!input_ready && dark < 40) begin dark++; tick(); end
    chk("tail_gap", 32'(dark), 32'd2);
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic press_all(input int n);
    logic [3:0] b;
    for (int i = 0; i < n; i++) begin
      b = 4'(1 << exp_syms[i]);
      butt = b;
      tick();
      butt = 4'd0;
      if (i < n - 1) begin
        chk("echo", 32'(lamp), 32'(b));
        chk("still_input", 32'(input_ready), 32'd1);
        tick();
      end
    end
  endtask

  initial begin
    int n;
    logic [3:0] b;
    rst_n = 1'b0; ena = 1'b0; start = 1'b0; butt = 4'd0;
    #1;
    chk("rst_lamp", 32'(lamp), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1; cnt = 0; ena = 1'b1;
    repeat (10) tick();
    chk("idle_lamp", 32'(lamp), 32'd0);
    chk("idle_level", 32'(level), 32'd0);
    chk("idle_win", 32'(win), 32'd0);
    chk("idle_lose", 32'(lose), 32'd0);
    chk("idle_ready", 32'(input_ready), 32'd0);

    // Fresh reset so the start edge samples seed_cnt == 5.
    rst_n = 1'b0; cnt = 0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    start_game();

    for (int r = 1; r <= 3; r++) begin
      run_round(r);
      press_all(r);
      if (r < 3) begin
        chk("next_level", 32'(level), 32'(r + 1));
        chk("pause_ready", 32'(input_ready), 32'd0);
      end
    end
    chk("win", 32'(win), 32'd1);
    chk("win_level", 32'(level), 32'd3);
    chk("win_lamp0", 32'(lamp), 32'hF);
    for (int i = 1; i < 12; i++) begin
      tick();
      chk("win_toggle", 32'(lamp), ((i / 4) % 2 == 0) ? 32'hF : 32'h0);
    end

    // Wrong button.
    start_game();
    run_round(1);
    b = 4'(1 << ((exp_syms[0] + 1) % 4));
    butt = b;
    tick();
    butt = 4'd0;
    chk("wrong_lose", 32'(lose), 32'd1);
    chk("wrong_lamp", 32'(lamp), 32'(1 << exp_syms[0]));
    chk("wrong_ready", 32'(input_ready), 32'd0);
    repeat (3) tick();
    chk("lose_steady", 32'(lamp), 32'(1 << exp_syms[0]));
    chk("lose_level", 32'(level), 32'd1);

    // Two buttons rising together.
    start_game();
    run_round(1);
    butt = 4'b0011;
    tick();
    butt = 4'd0;
    chk("multi_lose", 32'(lose), 32'd1);

    // Timeout, with a clock-enable stall that must freeze the timer.
    start_game();
    run_round(1);
    ena = 1'b0;
    repeat (20) tick();
    chk("stall_ready", 32'(input_ready), 32'd1);
    chk("stall_lose", 32'(lose), 32'd0);
    ena = 1'b1;
    n = 0;
    while (!lose && n < 200) begin tick(); n++; end
    chk("timeout_cycles", 32'(n), 32'd50);

    // Asynchronous reset during playback.
    start_game();
    n = 0;
    while (lamp == 4'd0 && n < 40) begin tick(); n++; end
    chk("pre_rst_lamp_on", 32'(lamp != 4'd0), 32'd1);
    rst_n = 1'b0; cnt = 0;
    #1;
    chk("async_lamp", 32'(lamp), 32'd0);
    chk("async_level", 32'(level), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_lamp", 32'(lamp), 32'd0);
    chk("post_rst_level", 32'(level), 32'd0);
    chk("post_rst_ready", 32'(input_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
